// File: rtl/risc8_pkg.sv
// rtl/risc8_pkg.sv - shared opcode, ALU, write-back and state encodings for the RISC-8 core
package risc8_pkg;

  // Instruction opcodes (instr[15:12]); 4'hB..4'hE are undefined
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_LD  = 4'h7;
  localparam logic [3:0] OP_ST  = 4'h8;
  localparam logic [3:0] OP_BEQ = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation select
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  // Register file write-back source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  // Control FSM states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // ALU operation for an opcode; BEQ compares by subtraction
  function automatic logic [2:0] alu_op_of(input logic [3:0] opcode);
    logic [2:0] op;
    case (opcode)
      OP_ADD:  op = ALU_ADD;
      OP_SUB:  op = ALU_SUB;
      OP_AND:  op = ALU_AND;
      OP_OR:   op = ALU_OR;
      OP_XOR:  op = ALU_XOR;
      OP_BEQ:  op = ALU_SUB;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decodificator_instructiuni.sv
// rtl/decodificator_instructiuni.sv - splits a 16-bit instruction into its fields
module decodificator_instructiuni
  import risc8_pkg::*;
(
  input  logic [15:0] instr,
  output logic [3:0]  opcode,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [3:0]  rd,
  output logic [7:0]  imm,
  output logic        is_alu
);

  assign opcode = instr[15:12];
  assign rs     = instr[11:8];
  assign rt     = instr[7:4];
  assign rd     = instr[3:0];
  assign imm    = instr[7:0];

  // Register-to-register ALU instructions write rd in WB
  always_comb begin
    is_alu = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: is_alu = 1'b1;
      default:                               is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/unitate_control.sv
// rtl/unitate_control.sv - multi-cycle control FSM of the RISC-8 core (owns PC and IR)
module unitate_control
  import risc8_pkg::*;
#(
  parameter int                    PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic [3:0]          rf_ra1,
  output logic [3:0]          rf_ra2,
  output logic [3:0]          rf_wa,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [2:0]          alu_op,
  input  logic                alu_zero,
  output logic                halted,
  output logic                illegal
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  logic [PC_WIDTH-1:0] pc;
  logic [15:0]         ir;

  logic [3:0]          opcode;
  logic [3:0]          rs;
  logic [3:0]          rt;
  logic [3:0]          rd;
  logic [7:0]          imm;
  logic                is_alu;

  logic [PC_WIDTH-1:0] jmp_target;
  logic [PC_WIDTH-1:0] branch_off;

  decodificator_instructiuni u_dec (
    .instr  (ir),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .imm    (imm),
    .is_alu (is_alu)
  );

  // Register read ports follow IR, so they hold from DECODE until the next IR load
  assign rf_ra1    = rs;
  assign rf_ra2    = rt;
  assign imem_addr = pc;

  // JMP target is the immediate; BEQ offset is rd sign-extended to PC width
  assign jmp_target = PC_WIDTH'(imm);
  assign branch_off = {{(PC_WIDTH-4){rd[3]}}, rd};

  // Control FSM: every output is registered and set on the edge entering its state.
  // After reset imem_req is 0, so the first FETCH cycle only raises the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      dmem_we  <= 1'b0;
      rf_wa    <= '0;
      rf_we    <= 1'b0;
      wb_sel   <= WB_ALU;
      alu_op   <= ALU_ADD;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_data;
            pc       <= pc + PC_ONE;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end

        S_DECODE: begin
          case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_BEQ: begin
              alu_op <= alu_op_of(opcode);
              state  <= S_EXEC;
            end
            OP_LDI: begin
              rf_wa  <= rs;
              wb_sel <= WB_IMM;
              rf_we  <= 1'b1;
              state  <= S_WB;
            end
            OP_LD, OP_ST: begin
              dmem_req <= 1'b1;
              dmem_we  <= (opcode == OP_ST);
              state    <= S_MEM;
            end
            OP_NOP: begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_JMP: begin
              pc       <= jmp_target;
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
            OP_HLT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= 1'b1;
              state   <= S_HALT;
            end
          endcase
        end

        S_EXEC: begin
          if (is_alu) begin
            rf_wa  <= rd;
            wb_sel <= WB_ALU;
            rf_we  <= 1'b1;
            state  <= S_WB;
          end else begin
            // BEQ: PC already points past the branch
            if (alu_zero) begin
              pc <= pc + branch_off;
            end
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end

        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (opcode == OP_LD) begin
              rf_wa  <= rt;
              wb_sel <= WB_MEM;
              rf_we  <= 1'b1;
              state  <= S_WB;
            end else begin
              imem_req <= 1'b1;
              state    <= S_FETCH;
            end
          end
        end

        S_WB: begin
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end

        S_HALT: begin
          state <= S_HALT;
        end

        default: begin
          state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unitate_control.sv
// tb/tb_unitate_control.sv - directed self-checking bench for unitate_control
module tb_unitate_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_ack  = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack  = 1'b0;
  logic [3:0]  rf_ra1;
  logic [3:0]  rf_ra2;
  logic [3:0]  rf_wa;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  alu_op;
  logic        alu_zero  = 1'b0;
  logic        halted;
  logic        illegal;

  int passed  = 0;
  int total   = 0;
  int overlap = 0;

  unitate_control #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .imem_ack  (imem_ack),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_ack  (dmem_ack),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .rf_wa     (rf_wa),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .alu_zero  (alu_zero),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_req === 1'b1 && dmem_req === 1'b1) overlap++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_imem_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("imem_req_wait", 32'(imem_req), 32'd1);
  endtask

  // Acknowledge one fetch; returns at the negedge of the DECODE cycle
  task automatic fetch(input logic [15:0] w);
    wait_imem_req();
    imem_data = w;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h00);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_ra1", 32'(rf_ra1), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;

    // ADD r3, r1, r2: ack cycle, DECODE, EXEC, WB -> rf_we in 4th cycle
    fetch(16'h1123);
    chk("add_dec_ra1", 32'(rf_ra1), 32'd1);
    chk("add_dec_ra2", 32'(rf_ra2), 32'd2);
    chk("add_dec_pc", 32'(imem_addr), 32'h01);
    chk("add_dec_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("add_exec_aluop", 32'(alu_op), 32'd0);
    chk("add_exec_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("add_wb_we", 32'(rf_we), 32'd1);
    chk("add_wb_wa", 32'(rf_wa), 32'd3);
    chk("add_wb_sel", 32'(wb_sel), 32'd0);
    @(negedge clk);
    chk("add_we_pulse", 32'(rf_we), 32'd0);
    chk("add_next_req", 32'(imem_req), 32'd1);
    chk("add_pc", 32'(imem_addr), 32'h01);

    // LD r5, [r1] with dmem_ack in the 4th request cycle
    fetch(16'h7150);
    chk("ld_dec_dreq", 32'(dmem_req), 32'd0);
    @(negedge clk);
    chk("ld_mem1_req", 32'(dmem_req), 32'd1);
    chk("ld_mem1_we", 32'(dmem_we), 32'd0);
    chk("ld_mem1_ireq", 32'(imem_req), 32'd0);
    @(negedge clk);
    chk("ld_mem2_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    chk("ld_mem3_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    chk("ld_mem4_req", 32'(dmem_req), 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("ld_wb_dreq", 32'(dmem_req), 32'd0);
    chk("ld_wb_we", 32'(rf_we), 32'd1);
    chk("ld_wb_wa", 32'(rf_wa), 32'd5);
    chk("ld_wb_sel", 32'(wb_sel), 32'd2);
    @(negedge clk);
    chk("ld_we_pulse", 32'(rf_we), 32'd0);
    chk("ld_pc", 32'(imem_addr), 32'h02);

    // LDI rA, 0x42: 3 cycles
    fetch(16'h6A42);
    chk("ldi_dec_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk("ldi_wb_we", 32'(rf_we), 32'd1);
    chk("ldi_wb_wa", 32'(rf_wa), 32'hA);
    chk("ldi_wb_sel", 32'(wb_sel), 32'd1);

    // ST [r3], r4 with immediate ack: 3 cycles
    fetch(16'h8340);
    @(negedge clk);
    chk("st_mem_req", 32'(dmem_req), 32'd1);
    chk("st_mem_we", 32'(dmem_we), 32'd1);
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("st_done_dreq", 32'(dmem_req), 32'd0);
    chk("st_done_ireq", 32'(imem_req), 32'd1);
    chk("st_done_we", 32'(rf_we), 32'd0);
    chk("st_pc", 32'(imem_addr), 32'h04);

    // JMP 0x05, then BEQ -2 taken
    fetch(16'hA005);
    @(negedge clk);
    chk("jmp_req", 32'(imem_req), 32'd1);
    chk("jmp_pc", 32'(imem_addr), 32'h05);
    fetch(16'h912E);
    chk("beq_dec_pc", 32'(imem_addr), 32'h06);
    @(negedge clk);
    chk("beq_exec_aluop", 32'(alu_op), 32'd1);
    alu_zero = 1'b1;
    @(negedge clk);
    alu_zero = 1'b0;
    chk("beq_taken_pc", 32'(imem_addr), 32'h04);
    chk("beq_taken_req", 32'(imem_req), 32'd1);

    // Same BEQ at 0x05 not taken
    fetch(16'hA005);
    fetch(16'h912E);
    @(negedge clk);
    @(negedge clk);
    chk("beq_not_taken_pc", 32'(imem_addr), 32'h06);

    // JMP 0xFF, NOP at 0xFF wraps PC to 0x00
    fetch(16'hA0FF);
    @(negedge clk);
    chk("jmp_ff_pc", 32'(imem_addr), 32'hFF);
    fetch(16'h0000);
    chk("nop_wrap_pc", 32'(imem_addr), 32'h00);
    @(negedge clk);
    chk("nop_next_req", 32'(imem_req), 32'd1);

    // Undefined opcode 0xC halts with illegal; stray acks ignored
    fetch(16'hC000);
    @(negedge clk);
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_illegal", 32'(illegal), 32'd1);
    imem_ack = 1'b1;
    imem_data = 16'h1123;
    dmem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("ill_no_ireq", 32'(imem_req), 32'd0);
    chk("ill_no_dreq", 32'(dmem_req), 32'd0);
    chk("ill_pc_frozen", 32'(imem_addr), 32'h01);
    chk("ill_ir_frozen", 32'(rf_ra1), 32'hC >> 4);
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ill_rst_pc", 32'(imem_addr), 32'h00);
    chk("ill_rst_halted", 32'(halted), 32'd0);
    chk("ill_rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    chk("ill_rst_req", 32'(imem_req), 32'd1);

    // Reset while a fetch is pending with ack present
    imem_data = 16'h1123;
    imem_ack  = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_ir", 32'(rf_ra1), 32'd0);
    chk("midrst_pc", 32'(imem_addr), 32'h00);
    imem_ack = 1'b0;
    rst      = 1'b0;
    fetch(16'h1123);
    chk("midrst_refetch_ra1", 32'(rf_ra1), 32'd1);
    chk("midrst_refetch_pc", 32'(imem_addr), 32'h01);
    repeat (3) @(negedge clk);

    // HLT stops without the illegal flag
    fetch(16'hF000);
    @(negedge clk);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_illegal", 32'(illegal), 32'd0);
    @(negedge clk);
    chk("hlt_no_req", 32'(imem_req), 32'd0);

    chk("req_overlap", 32'(overlap), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
